regfile_wb_scheduler: RTL and testbench

Write-back scheduler and scoreboard for the 32×32 register file. It shares the file's single write port (`wf`/`ws`/`wd`) between two write-back requesters: A, the ALU pipe, and B, the load/FPU pipe. Arbitration is round-robin. It also keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards. It sits between the execute/memory stages and the register file, and drives that file's write inputs from registered outputs.

---
 rtl/regfile_wb_scheduler_if.sv | 50 +++++
 rtl/regfile_wb_scheduler.sv | 98 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Port bundle for the register-file write-back scheduler: issue-stage query,
// two write-back requesters (A = ALU, B = load/FPU) and the register-file write port.
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
);
  logic              issue_valid;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_use_rs1;
  logic              issue_use_rs2;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic              issue_ready;

  // Handshake: a write-back transfers at a rising edge where x_valid & x_ready are
  // both high; x_ready is a combinational grant and never depends on the write port.
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              wf;
  logic [ADDR_W-1:0] ws;
  logic [DATA_W-1:0] wd;
  logic [NREG-1:0]   busy;
  logic              wb_err;
  logic              dbg_prio;

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_use_rs1, issue_use_rs2,
           issue_rs1, issue_rs2,
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output issue_ready, a_ready, b_ready,
    output wf, ws, wd, busy, wb_err, dbg_prio
  );

  modport master (
    output issue_valid, issue_we, issue_rd, issue_use_rs1, issue_use_rs2,
           issue_rs1, issue_rs2,
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  issue_ready, a_ready, b_ready,
    input  wf, ws, wd, busy, wb_err, dbg_prio
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter sharing one register-file write port between two write-back
// pipes, plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_wb_scheduler_if.slave  bus
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e             prio_q, prio_d;
  logic              wf_q, wf_d;
  logic [ADDR_W-1:0] ws_q, ws_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;
  logic              clr_q, clr_d;

  logic              stall;
  logic              issue_fire;
  logic              a_gnt;
  logic              b_gnt;
  logic              hs;
  logic [ADDR_W-1:0] hs_rd;
  logic [DATA_W-1:0] hs_data;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;

  always_comb begin
    stall = (bus.issue_use_rs1 & busy_q[bus.issue_rs1])
          | (bus.issue_use_rs2 & busy_q[bus.issue_rs2])
          | (bus.issue_we      & busy_q[bus.issue_rd]);
    issue_fire = bus.issue_valid & ~stall & bus.issue_we;

    // Grants are forced low while reset is asserted so nothing is accepted then.
    a_gnt = rst_n & bus.a_valid & (~bus.b_valid | (prio_q == PRIO_A));
    b_gnt = rst_n & bus.b_valid & (~bus.a_valid | (prio_q == PRIO_B));
    hs      = a_gnt | b_gnt;
    hs_rd   = a_gnt ? bus.a_rd   : bus.b_rd;
    hs_data = a_gnt ? bus.a_data : bus.b_data;

    set_mask = '0;
    if (issue_fire) set_mask[bus.issue_rd] = 1'b1;
    clr_mask = '0;
    if (wf_q && clr_q) clr_mask[ws_q] = 1'b1;
    // A set and a clear of the same bit at one edge resolve to set.
    busy_d = (busy_q & ~clr_mask) | set_mask;

    prio_d = prio_q;
    if (a_gnt)      prio_d = PRIO_B;
    else if (b_gnt) prio_d = PRIO_A;

    wf_d = hs;
    ws_d = hs ? hs_rd   : ws_q;
    wd_d = hs ? hs_data : wd_q;
    // A write-back to a register that was not busy must not clear it later.
    clr_d = hs & busy_q[hs_rd];
    err_d = err_q | (hs & ~busy_q[hs_rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_A;
      wf_q   <= 1'b0;
      ws_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      wf_q   <= wf_d;
      ws_q   <= ws_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      clr_q  <= clr_d;
    end
  end

  assign bus.issue_ready = ~stall;
  assign bus.a_ready     = a_gnt;
  assign bus.b_ready     = b_gnt;
  assign bus.wf          = wf_q;
  assign bus.ws          = ws_q;
  assign bus.wd          = wd_q;
  assign bus.busy        = busy_q;
  assign bus.wb_err      = err_q;
  assign bus.dbg_prio    = prio_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenario tasks plus randomized traffic
// scored against a behavioural model of grants, writes and the busy scoreboard.
module tb_regfile_wb_scheduler;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) bus ();

  regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [NREG-1:0]          m_busy   = '0;
  logic                     m_prio   = 1'b0;
  logic                     m_err    = 1'b0;
  logic                     m_wf     = 1'b0;
  logic                     m_clr_ok = 1'b0;
  logic [ADDR_W-1:0]        m_ws     = '0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  // 0 = nobody, 1 = A, 2 = B
  function automatic int ref_grant(logic av, logic bv, logic pr);
    if (av && !bv) return 1;
    if (bv && !av) return 2;
    if (av && bv)  return pr ? 2 : 1;
    return 0;
  endfunction

  function automatic logic ref_stall(logic [NREG-1:0] bz);
    return (bus.issue_use_rs1 && bz[bus.issue_rs1]) ||
           (bus.issue_use_rs2 && bz[bus.issue_rs2]) ||
           (bus.issue_we      && bz[bus.issue_rd]);
  endfunction

  task automatic model_edge();
    int                g;
    logic [NREG-1:0]   old;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] dat;
    if (!rst_n) begin
      m_busy = '0; m_prio = 1'b0; m_err = 1'b0; m_wf = 1'b0; m_clr_ok = 1'b0; m_ws = '0;
      exp_q.delete();
      return;
    end
    old = m_busy;
    g   = ref_grant(bus.a_valid, bus.b_valid, m_prio);
    if (m_wf && m_clr_ok) m_busy[m_ws] = 1'b0;
    if (bus.issue_valid && bus.issue_we && !ref_stall(old)) m_busy[bus.issue_rd] = 1'b1;
    if (g != 0) begin
      rd  = (g == 1) ? bus.a_rd   : bus.b_rd;
      dat = (g == 1) ? bus.a_data : bus.b_data;
      m_clr_ok = old[rd];
      if (!old[rd]) m_err = 1'b1;
      exp_q.push_back({rd, dat});
      m_wf   = 1'b1;
      m_ws   = rd;
      m_prio = (g == 1);
    end else begin
      m_wf = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_edge();

  // ---------------- scoreboard (sampled on the falling edge) ----------------
  always @(negedge clk) begin
    int                       g;
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst_n) begin
      g = ref_grant(bus.a_valid, bus.b_valid, m_prio);
      n_checks++;
      if (bus.issue_ready !== !ref_stall(m_busy))
        $display("FAIL sb_issue_ready t=%0t got=%b exp=%b", $time, bus.issue_ready, !ref_stall(m_busy));
      else n_pass++;
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== {g == 1, g == 2})
        $display("FAIL sb_grant t=%0t got a/b=%b%b exp=%b%b", $time, bus.a_ready, bus.b_ready, g == 1, g == 2);
      else n_pass++;
      n_checks++;
      if (bus.wf !== m_wf) $display("FAIL sb_wf t=%0t got=%b exp=%b", $time, bus.wf, m_wf);
      else n_pass++;
      if (m_wf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_write t=%0t got=write exp=queue entry (queue empty)", $time);
        end else begin
          e = exp_q.pop_front();
          if ({bus.ws, bus.wd} !== e)
            $display("FAIL sb_write t=%0t got ws=%0d wd=%h exp ws=%0d wd=%h", $time, bus.ws, bus.wd,
                     e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          else n_pass++;
        end
      end
      n_checks++;
      if (bus.busy !== m_busy) $display("FAIL sb_busy t=%0t got=%h exp=%h", $time, bus.busy, m_busy);
      else n_pass++;
      n_checks++;
      if (bus.wb_err !== m_err) $display("FAIL sb_wb_err t=%0t got=%b exp=%b", $time, bus.wb_err, m_err);
      else n_pass++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0; bus.issue_we = 1'b0; bus.issue_rd = '0;
    bus.issue_use_rs1 = 1'b0; bus.issue_use_rs2 = 1'b0;
    bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
  endtask

  task automatic drive_issue(input logic [ADDR_W-1:0] rd);
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = rd;
    bus.issue_use_rs1 = 1'b0; bus.issue_use_rs2 = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [ADDR_W-1:0] pick_rd();
    logic [ADDR_W-1:0] r;
    r = ADDR_W'($urandom_range(0, NREG - 1));
    if (m_busy != '0 && $urandom_range(0, 4) != 0)
      for (int k = 0; k < 64 && !m_busy[r]; k++) r = ADDR_W'($urandom_range(0, NREG - 1));
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick(); tick();
    bus.a_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.wf, bus.busy, bus.wb_err, bus.a_ready, bus.issue_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_hold got wf=%b busy=%h err=%b a_rdy=%b iss_rdy=%b exp 0/0/0/0/1",
               bus.wf, bus.busy, bus.wb_err, bus.a_ready, bus.issue_ready);
    else n_pass++;
    drive_idle();
    rst_n = 1'b1;
    tick();
    drive_issue(5'd1); tick();
    drive_issue(5'd2); tick();
    drive_idle();
    bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = $urandom;
    tick();
    drive_idle();
    n_checks++;
    if ({bus.wf, bus.busy, bus.wb_err} !== {1'b1, 32'h0000_0006, 1'b1})
      $display("FAIL reset_pre got wf=%b busy=%h err=%b exp wf=1 busy=00000006 err=1", bus.wf, bus.busy, bus.wb_err);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.wf, bus.ws, bus.wd, bus.busy, bus.wb_err} !== {1'b0, 5'd0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_async got wf=%b ws=%0d wd=%h busy=%h err=%b exp all zero",
               bus.wf, bus.ws, bus.wd, bus.busy, bus.wb_err);
    else n_pass++;
    n_checks++;
    if ({bus.a_ready, bus.b_ready, bus.issue_ready} !== 3'b001)
      $display("FAIL reset_ready got a=%b b=%b iss=%b exp a=0 b=0 iss=1", bus.a_ready, bus.b_ready, bus.issue_ready);
    else n_pass++;
    tick();
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] da, db;
    logic [ADDR_W-1:0] exp_ws;
    logic [DATA_W-1:0] exp_wd;
    for (int i = 0; i < 4; i++) begin
      da = $urandom; db = $urandom;
      bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = da;
      bus.b_valid = 1'b1; bus.b_rd = 5'd6; bus.b_data = db;
      #1;
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL contention_grant%0d got a/b=%b%b exp=%s", i, bus.a_ready, bus.b_ready, (i % 2 == 0) ? "A" : "B");
      else n_pass++;
      tick();
      exp_ws = (i % 2 == 0) ? 5'd5 : 5'd6;
      exp_wd = (i % 2 == 0) ? da : db;
      n_checks++;
      if ({bus.wf, bus.ws, bus.wd} !== {1'b1, exp_ws, exp_wd})
        $display("FAIL contention_ws%0d got wf=%b ws=%0d wd=%h exp wf=1 ws=%0d wd=%h", i, bus.wf, bus.ws, bus.wd, exp_ws, exp_wd);
      else n_pass++;
    end
    drive_idle();
    tick();
  endtask

  task automatic test_single_wb();
    drive_issue(5'd3);
    tick();
    drive_idle();
    n_checks++;
    if (bus.busy[3] !== 1'b1) $display("FAIL single_busy_set got=%b exp=1", bus.busy[3]);
    else n_pass++;
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b1) $display("FAIL single_a_ready got=%b exp=1", bus.a_ready);
    else n_pass++;
    tick();
    drive_idle();
    n_checks++;
    if ({bus.wf, bus.ws, bus.wd, bus.busy[3]} !== {1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1})
      $display("FAIL single_write got wf=%b ws=%0d wd=%h busy3=%b exp 1/3/deadbeef/1", bus.wf, bus.ws, bus.wd, bus.busy[3]);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.wf, bus.busy[3]} !== 2'b00) $display("FAIL single_clear got wf=%b busy3=%b exp 0/0", bus.wf, bus.busy[3]);
    else n_pass++;
  endtask

  task automatic test_hazard();
    drive_issue(5'd7);
    tick();
    drive_idle();
    bus.issue_valid = 1'b1; bus.issue_use_rs2 = 1'b1; bus.issue_rs2 = 5'd7;
    bus.issue_use_rs1 = 1'b1; bus.issue_rs1 = 5'd8;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b0) $display("FAIL raw_stall0 got=%b exp=0", bus.issue_ready);
    else n_pass++;
    tick();
    bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = $urandom;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b0) $display("FAIL raw_stall_hs got=%b exp=0", bus.issue_ready);
    else n_pass++;
    tick();
    bus.a_valid = 1'b0;
    n_checks++;
    if ({bus.wf, bus.issue_ready} !== 2'b10) $display("FAIL raw_stall_wf got wf=%b rdy=%b exp wf=1 rdy=0", bus.wf, bus.issue_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.issue_ready !== 1'b1) $display("FAIL raw_release got=%b exp=1", bus.issue_ready);
    else n_pass++;
    drive_issue(5'd7);
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b1) $display("FAIL waw_free got=%b exp=1", bus.issue_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.issue_ready !== 1'b0) $display("FAIL waw_stall got=%b exp=0", bus.issue_ready);
    else n_pass++;
    drive_idle();
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = $urandom;
    tick();
    drive_idle();
    tick(); tick();
  endtask

  task automatic test_error();
    logic [DATA_W-1:0] d;
    do_reset();
    drive_issue(5'd10);
    tick();
    drive_idle();
    n_checks++;
    if (bus.wb_err !== 1'b0) $display("FAIL err_clean got=%b exp=0", bus.wb_err);
    else n_pass++;
    d = $urandom;
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = d;
    #1;
    n_checks++;
    if (bus.b_ready !== 1'b1) $display("FAIL err_b_ready got=%b exp=1", bus.b_ready);
    else n_pass++;
    tick();
    drive_idle();
    n_checks++;
    if ({bus.wf, bus.ws, bus.wd, bus.wb_err, bus.busy} !== {1'b1, 5'd9, d, 1'b1, 32'h0000_0400})
      $display("FAIL err_write got wf=%b ws=%0d wd=%h err=%b busy=%h exp 1/9/%h/1/00000400",
               bus.wf, bus.ws, bus.wd, bus.wb_err, bus.busy, d);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({bus.wb_err, bus.busy} !== {1'b1, 32'h0000_0400})
      $display("FAIL err_sticky got err=%b busy=%h exp err=1 busy=00000400", bus.wb_err, bus.busy);
    else n_pass++;
    bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = $urandom;
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      bus.issue_valid   = ($urandom_range(0, 2) != 0);
      bus.issue_we      = ($urandom_range(0, 3) != 0);
      bus.issue_rd      = ADDR_W'($urandom_range(0, NREG - 1));
      bus.issue_use_rs1 = $urandom_range(0, 1);
      bus.issue_use_rs2 = $urandom_range(0, 1);
      bus.issue_rs1     = ADDR_W'($urandom_range(0, NREG - 1));
      bus.issue_rs2     = ADDR_W'($urandom_range(0, NREG - 1));
      bus.a_valid       = ($urandom_range(0, 2) != 0);
      bus.a_rd          = pick_rd();
      bus.a_data        = $urandom;
      bus.b_valid       = ($urandom_range(0, 2) != 0);
      bus.b_rd          = pick_rd();
      bus.b_data        = $urandom;
      tick();
    end
    drive_idle();
    repeat (4) tick();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_contention();
    test_single_wb();
    test_hazard();
    test_error();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
